prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- D, 12, program counter width.
- IW, 9, instruction width.
- SD, 4, return-stack depth (entries).
- HALT_CODE, 9'b101111111, instruction pattern that halts execution.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, begin or restart execution from address 0.
- stall, input, 1, hold program counter and all state this cycle.
- instr, input, IW, machine code currently fetched at prog_ctr.
- br_abs, input, 1, conditional absolute branch request.
- br_rel, input, 1, conditional relative branch request.
- br_invert, input, 1, take the branch when the selected flag is 0.
- br_flag_sel, input, 1, flag select: 1 = zero flag, 0 = negative flag.
- flag_ngtv, input, 1, registered negative flag.
- flag_zero, input, 1, registered zero flag.
- call, input, 1, unconditional call to target.
- ret, input, 1, unconditional return.
- target, input, D, absolute address, or signed two's-complement relative offset.
- prog_ctr, output, D, current fetch address.
- running, output, 1, high in RUN.
- done, output, 1, high in HALTED.
- stack_err, output, 1, sticky return-stack overflow/underflow indication.
- cycle_count, output, 16, count of executed RUN cycles.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, RUN and HALTED.
REQ-004 IDLE SHALL go to RUN on start; prog_ctr SHALL be 0 on entry to RUN.
REQ-005 RUN SHALL go to HALTED in a non-stalled cycle where instr==HALT_CODE; prog_ctr SHALL hold the halt address.
REQ-006 HALTED SHALL go to RUN on start, clearing prog_ctr, the stack, stack_err and cycle_count.
REQ-007 start SHALL be ignored while in RUN.
REQ-008 In IDLE and HALTED, prog_ctr SHALL hold and all branch, call and ret inputs SHALL be ignored.
REQ-009 Branch-taken SHALL equal (br_flag_sel ? flag_zero : flag_ngtv) XOR br_invert, evaluated in the same cycle as the request.
REQ-010 In a non-stalled RUN cycle, next prog_ctr SHALL follow this priority:
- halt: hold.
- ret: popped address.
- call: target.
- br_abs taken: target.
- br_rel taken: prog_ctr + target, modulo 2^D.
- otherwise: prog_ctr + 1, modulo 2^D.
REQ-011 A not-taken branch SHALL advance prog_ctr by 1.
REQ-012 When br_abs and br_rel are both asserted, br_abs SHALL win.
REQ-013 A call SHALL push prog_ctr+1 (mod 2^D) onto the return stack.
REQ-014 When call and ret are asserted together, ret SHALL win and the call SHALL be discarded, with no push.
REQ-015 A call with SD entries already held SHALL set stack_err, leave the stack unchanged and go to HALTED.
REQ-016 A ret with 0 entries held SHALL set stack_err and go to HALTED.
REQ-017 A cycle with stall=1 SHALL change no state, and cycle_count SHALL not increment.
REQ-018 cycle_count SHALL increment once per non-stalled RUN cycle, including the halting cycle, and saturate at 16'hFFFF.
REQ-019 All outputs SHALL be registered and all updates SHALL take effect on the clk edge following the request (latency 1).

Reset
REQ-020 When reset is high at a clk edge, the block SHALL enter IDLE with prog_ctr=0, running=0, done=0, stack_err=0, cycle_count=0 and stack pointer 0.
REQ-021 reset SHALL take priority over start, stall and all other inputs, including mid-run and mid-stall.

Configuration
REQ-022 With macro PROG_SEQUENCER_CALL_STACK_EN defined, the return stack and REQ-013 to REQ-016 SHALL be implemented.
REQ-023 With PROG_SEQUENCER_CALL_STACK_EN undefined:
- call and ret SHALL be ignored and treated as sequential advance.
- stack_err SHALL be tied to 0.
- no stack storage SHALL be synthesised.

Verification
REQ-024 Sequential run, halt and restart:
- reset, start, instr non-halt for 5 cycles, then instr=HALT_CODE -> prog_ctr steps 0,1,2,3,4,5, then holds 5; done=1; cycle_count=6.
- start again -> prog_ctr=0, done=0, running=1.
REQ-025 Relative branch backward with wrap: prog_ctr=2, br_rel=1, br_flag_sel=1, flag_zero=1, br_invert=0, target=12'hFFD -> prog_ctr=12'hFFF.
- Repeat with br_invert=1 -> prog_ctr=3.
REQ-026 Branch priority and stall: br_abs=1 with br_rel=1, both taken, target=12'h040 -> prog_ctr=12'h040.
- stall=1 for 3 cycles -> prog_ctr and cycle_count unchanged.
REQ-027 Call/return: call at prog_ctr=10 with target=12'h100 -> prog_ctr=12'h100; ret -> prog_ctr=11.
- SD+1 nested calls -> stack_err=1, done=1.
- ret on an empty stack -> stack_err=1, done=1.
REQ-028 Reset mid-run: reset asserted while RUN with prog_ctr=12'h0A7 and stall=1 -> next edge gives IDLE with all outputs 0.
- Macro undefined: call=1 -> prog_ctr+1, stack_err=0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: IDLE/RUN/HALTED controller that produces the fetch
// address, resolves conditional absolute/relative branches and keeps a
// RUN-cycle counter.
// Optional feature macro: PROG_SEQUENCER_CALL_STACK_EN enables the return
// stack (call/ret handling and stack_err). Without it, call and ret behave
// as plain sequential advance and stack_err is constant 0.
module prog_sequencer #(
  parameter int D = 12,
  parameter int IW = 9,
  parameter int SD = 4,
  parameter logic [IW-1:0] HALT_CODE = 9'b101111111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic [IW-1:0] instr,
  input  logic          br_abs,
  input  logic          br_rel,
  input  logic          br_invert,
  input  logic          br_flag_sel,
  input  logic          flag_ngtv,
  input  logic          flag_zero,
  input  logic          call,
  input  logic          ret,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          stack_err,
  output logic [15:0]   cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          running_q;
  logic          done_q;
  logic [D-1:0]  pc_inc;
  logic          br_taken;

  assign pc_inc   = pc_q + D'(1);
  // The selected flag, optionally inverted, decides any branch this cycle.
  assign br_taken = (br_flag_sel ? flag_zero : flag_ngtv) ^ br_invert;

`ifdef PROG_SEQUENCER_CALL_STACK_EN
  // Stack pointer counts held entries, so it needs to represent 0..SD.
  localparam int SPW = $clog2(SD + 1);
  localparam int SAW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(SD);
  localparam logic [SAW-1:0] ONE_IDX = SAW'(1);

  logic [D-1:0]   stack_mem [SD];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push_en;
  logic [SAW-1:0] push_idx;
  logic [SAW-1:0] pop_idx;

  // Push goes to the slot at the current depth; pop reads the slot below it.
  assign push_idx = SAW'(sp_q);
  assign pop_idx  = SAW'(sp_q) - ONE_IDX;
`endif

  // Next-state selection: everything holds by default, and a stalled cycle
  // never leaves the defaults.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PROG_SEQUENCER_CALL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    if (!stall) begin
      unique case (state_q)
        IDLE, HALTED: begin
          // Branch/call/ret are ignored here; only start does anything.
          if (start) begin
            state_d = RUN;
            pc_d    = '0;
            cnt_d   = '0;
`ifdef PROG_SEQUENCER_CALL_STACK_EN
            sp_d    = '0;
            err_d   = 1'b0;
`endif
          end
        end
        RUN: begin
          // The halting cycle and stack-fault cycles still count.
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (instr == HALT_CODE) begin
            state_d = HALTED;
          end
`ifdef PROG_SEQUENCER_CALL_STACK_EN
          else if (ret) begin
            // ret beats call; a simultaneous call is simply dropped.
            if (sp_q == '0) begin
              err_d   = 1'b1;
              state_d = HALTED;
            end else begin
              pc_d = stack_mem[pop_idx];
              sp_d = sp_q - SPW'(1);
            end
          end else if (call) begin
            if (sp_q == SP_FULL) begin
              err_d   = 1'b1;
              state_d = HALTED;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
              pc_d    = target;
            end
          end
`endif
          else if (br_abs && br_taken) begin
            pc_d = target;
          end else if (br_rel && br_taken) begin
            pc_d = pc_q + target;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with prog_ctr on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALTED);
    end
  end

`ifdef PROG_SEQUENCER_CALL_STACK_EN
  // Stack pointer and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents beyond the pointer are don't-care, so
  // the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign stack_err = err_q;
`else
  logic unused_call_ret;
  assign unused_call_ret = call ^ ret;
  assign stack_err       = 1'b0;
`endif

  assign prog_ctr    = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer. Stack scenarios are selected by
// PROG_SEQUENCER_CALL_STACK_EN to match the build of the design.
module tb_prog_sequencer;

  localparam logic [8:0] HALT = 9'b101111111;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [8:0]  instr;
  logic        br_abs, br_rel, br_invert, br_flag_sel, flag_ngtv, flag_zero;
  logic        call, ret;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        running, done, stack_err;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  prog_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .instr(instr),
    .br_abs(br_abs), .br_rel(br_rel), .br_invert(br_invert),
    .br_flag_sel(br_flag_sel), .flag_ngtv(flag_ngtv), .flag_zero(flag_zero),
    .call(call), .ret(ret), .target(target), .prog_ctr(prog_ctr),
    .running(running), .done(done), .stack_err(stack_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    start = 0; stall = 0; instr = 9'h000; br_abs = 0; br_rel = 0;
    br_invert = 0; br_flag_sel = 0; flag_ngtv = 0; flag_zero = 0;
    call = 0; ret = 0; target = 12'h000;
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h running=%b done=%b stack_err=%b cycles=%0d",
             $time, prog_ctr, running, done, stack_err, cycle_count);
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1;
    step();
    step();
    reset = 0;
    checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", prog_ctr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", stack_err); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cycle_count); end
    // Without start the block stays idle.
    step();
    checks++; if (running !== 1'b0 || prog_ctr !== 12'h000) begin errors++; $display("FAIL idle_hold got run=%b pc=%h exp run=0 pc=000", running, prog_ctr); end
  endtask

  task automatic test_sequential();
    start = 1;
    step();
    start = 0;
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b1) begin errors++; $display("FAIL start got pc=%h run=%b exp pc=000 run=1", prog_ctr, running); end
    instr = 9'h000;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (prog_ctr !== 12'(i)) begin errors++; $display("FAIL seq_pc got %h exp %h", prog_ctr, 12'(i)); end
    end
    instr = HALT;
    step();
    checks++; if (prog_ctr !== 12'h005) begin errors++; $display("FAIL halt_pc got %h exp 005", prog_ctr); end
    checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt_flags got done=%b run=%b exp done=1 run=0", done, running); end
    checks++; if (cycle_count !== 16'd6) begin errors++; $display("FAIL halt_cnt got %0d exp 6", cycle_count); end
    // HALTED holds and ignores branch requests.
    instr = 9'h000; br_abs = 1; br_flag_sel = 1; flag_zero = 1; target = 12'h321;
    step();
    checks++; if (prog_ctr !== 12'h005 || cycle_count !== 16'd6) begin errors++; $display("FAIL halted_hold got pc=%h cnt=%0d exp pc=005 cnt=6", prog_ctr, cycle_count); end
    clr_in();
    start = 1;
    step();
    start = 0;
    checks++; if (prog_ctr !== 12'h000 || done !== 1'b0 || running !== 1'b1 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL restart got pc=%h done=%b run=%b cnt=%0d exp pc=000 done=0 run=1 cnt=0", prog_ctr, done, running, cycle_count);
    end
  endtask

  task automatic test_branch();
    // pc 0 -> 2, start held high to show it is ignored in RUN
    start = 1;
    step(); step();
    start = 0;
    checks++; if (prog_ctr !== 12'h002) begin errors++; $display("FAIL run_ignores_start got %h exp 002", prog_ctr); end
    br_rel = 1; br_flag_sel = 1; flag_zero = 1; br_invert = 0; target = 12'hFFD;
    step();
    checks++; if (prog_ctr !== 12'hFFF) begin errors++; $display("FAIL rel_back_wrap got %h exp FFF", prog_ctr); end
    clr_in();
    step();
    checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL inc_wrap got %h exp 000", prog_ctr); end
    br_abs = 1; br_flag_sel = 1; flag_zero = 1; target = 12'h002;
    step();
    checks++; if (prog_ctr !== 12'h002) begin errors++; $display("FAIL abs_taken got %h exp 002", prog_ctr); end
    clr_in();
    br_rel = 1; br_flag_sel = 1; flag_zero = 1; br_invert = 1; target = 12'hFFD;
    step();
    checks++; if (prog_ctr !== 12'h003) begin errors++; $display("FAIL rel_not_taken got %h exp 003", prog_ctr); end
    clr_in();
    br_abs = 1; br_flag_sel = 0; flag_ngtv = 1; flag_zero = 0; target = 12'h077;
    step();
    checks++; if (prog_ctr !== 12'h077) begin errors++; $display("FAIL abs_ngtv got %h exp 077", prog_ctr); end
    br_abs = 1; br_flag_sel = 0; flag_ngtv = 0; flag_zero = 1; target = 12'h300;
    step();
    checks++; if (prog_ctr !== 12'h078) begin errors++; $display("FAIL flag_select got %h exp 078", prog_ctr); end
    clr_in();
  endtask

  task automatic test_priority_stall();
    br_abs = 1; br_rel = 1; br_flag_sel = 1; flag_zero = 1; target = 12'h040;
    step();
    checks++; if (prog_ctr !== 12'h040) begin errors++; $display("FAIL abs_over_rel got %h exp 040", prog_ctr); end
    checks++; if (cycle_count !== 16'd9) begin errors++; $display("FAIL cnt_before_stall got %0d exp 9", cycle_count); end
    stall = 1; target = 12'h123; start = 1; instr = HALT;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (prog_ctr !== 12'h040 || cycle_count !== 16'd9 || running !== 1'b1) begin
        errors++; $display("FAIL stall_hold got pc=%h cnt=%0d run=%b exp pc=040 cnt=9 run=1", prog_ctr, cycle_count, running);
      end
    end
    clr_in();
    step();
    checks++; if (prog_ctr !== 12'h041 || cycle_count !== 16'd10) begin errors++; $display("FAIL after_stall got pc=%h cnt=%0d exp pc=041 cnt=10", prog_ctr, cycle_count); end
  endtask

`ifdef PROG_SEQUENCER_CALL_STACK_EN
  task automatic test_call_ret();
    br_abs = 1; br_flag_sel = 1; flag_zero = 1; target = 12'h00A;
    step();
    clr_in();
    call = 1; target = 12'h100;
    step();
    checks++; if (prog_ctr !== 12'h100) begin errors++; $display("FAIL call_target got %h exp 100", prog_ctr); end
    clr_in(); ret = 1;
    step();
    checks++; if (prog_ctr !== 12'h00B) begin errors++; $display("FAIL ret_addr got %h exp 00B", prog_ctr); end
    clr_in(); call = 1; target = 12'h200;
    step();
    call = 1; ret = 1; target = 12'h300;
    step();
    checks++; if (prog_ctr !== 12'h00C || stack_err !== 1'b0) begin errors++; $display("FAIL ret_over_call got pc=%h err=%b exp pc=00C err=0", prog_ctr, stack_err); end
    clr_in(); ret = 1;
    step();
    checks++; if (stack_err !== 1'b1 || done !== 1'b1 || prog_ctr !== 12'h00C) begin
      errors++; $display("FAIL underflow got err=%b done=%b pc=%h exp err=1 done=1 pc=00C", stack_err, done, prog_ctr);
    end
    clr_in(); start = 1;
    step();
    clr_in();
    checks++; if (stack_err !== 1'b0 || prog_ctr !== 12'h000 || running !== 1'b1) begin
      errors++; $display("FAIL err_clear got err=%b pc=%h run=%b exp err=0 pc=000 run=1", stack_err, prog_ctr, running);
    end
    call = 1; target = 12'h050;
    for (int i = 0; i < 4; i++) step();
    checks++; if (stack_err !== 1'b0 || running !== 1'b1 || prog_ctr !== 12'h050) begin
      errors++; $display("FAIL full_stack got err=%b run=%b pc=%h exp err=0 run=1 pc=050", stack_err, running, prog_ctr);
    end
    step();
    checks++; if (stack_err !== 1'b1 || done !== 1'b1 || prog_ctr !== 12'h050) begin
      errors++; $display("FAIL overflow got err=%b done=%b pc=%h exp err=1 done=1 pc=050", stack_err, done, prog_ctr);
    end
    clr_in(); start = 1;
    step();
    clr_in();
    step(); step(); step();
  endtask
`else
  task automatic test_call_ret();
    // pc is 041 here; call/ret behave as sequential advance
    call = 1; target = 12'h100;
    step();
    checks++; if (prog_ctr !== 12'h042 || stack_err !== 1'b0) begin errors++; $display("FAIL call_ignored got pc=%h err=%b exp pc=042 err=0", prog_ctr, stack_err); end
    clr_in(); ret = 1;
    step();
    checks++; if (prog_ctr !== 12'h043 || stack_err !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL ret_ignored got pc=%h err=%b run=%b exp pc=043 err=0 run=1", prog_ctr, stack_err, running); end
    call = 1; ret = 1;
    step();
    checks++; if (prog_ctr !== 12'h044) begin errors++; $display("FAIL callret_ignored got %h exp 044", prog_ctr); end
    clr_in();
  endtask
`endif

  task automatic test_reset_midrun();
    br_abs = 1; br_flag_sel = 1; flag_zero = 1; target = 12'h0A7;
    step();
    checks++; if (prog_ctr !== 12'h0A7) begin errors++; $display("FAIL pre_reset_pc got %h exp 0A7", prog_ctr); end
    stall = 1; reset = 1; start = 1;
    step();
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0 || stack_err !== 1'b0 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL midrun_reset got pc=%h run=%b done=%b err=%b cnt=%0d exp all 0", prog_ctr, running, done, stack_err, cycle_count);
    end
    clr_in(); reset = 0; stall = 1; start = 1;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stalled_start got run=%b exp 0", running); end
    stall = 0;
    step();
    checks++; if (running !== 1'b1 || prog_ctr !== 12'h000) begin errors++; $display("FAIL start_after_reset got run=%b pc=%h exp run=1 pc=000", running, prog_ctr); end
    clr_in();
  endtask

  initial begin
    reset = 1;
    clr_in();
    test_reset();
    test_sequential();
    test_branch();
    test_priority_stall();
    test_call_ret();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
